hamm_weight_enum: RTL and testbench

Sequential enumerator that performs the inverse of the 32-bit Hamming-weight unit. Given a weight `k`, it streams every 32-bit word whose population count is exactly `k`, in ascending numerical order, over a valid/ready handshake. It sits beside the popcount datapath in the Sort design and supplies test vectors and combination sets to downstream consumers.

---
 rtl/hamm_weight_enum.sv | 182 ++++++++++++++++++
 tb/tb_hamm_weight_enum.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hamm_weight_enum.sv
// Streams every 32-bit word of population count k in ascending order (Gosper's step).
// Optional popcount self-check on every handshake is built when HAMM_ENUM_CHECK_EN is defined.
module hamm_weight_enum #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       k,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] count,
  output logic             chk_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [5:0]       kq_q, kq_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] first_word_s, first_top_s, top_q_s;
  logic [WIDTH-1:0] low_bit_s, next_word_s;
  logic [WIDTH:0]   sum_s, ripple_s;
  logic             hs_s;

  // Trailing-zero count of a one-hot value; replaces the divide in Gosper's step.
  function automatic logic [5:0] ctz(input logic [WIDTH-1:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        n = i[5:0];
      end
    end
    return n;
  endfunction

  // Gosper's next-combination and the last-word patterns for both requested and stored weight.
  always_comb begin
    first_word_s = ~({WIDTH{1'b1}} << k);
    first_top_s  = ~({WIDTH{1'b1}} >> k);
    top_q_s      = ~({WIDTH{1'b1}} >> kq_q);
    low_bit_s    = word_q & (~word_q + {{(WIDTH-1){1'b0}}, 1'b1});
    sum_s        = {1'b0, word_q} + {1'b0, low_bit_s};
    ripple_s     = ((sum_s ^ {1'b0, word_q}) >> 2) >> ctz(low_bit_s);
    next_word_s  = ripple_s[WIDTH-1:0] | sum_s[WIDTH-1:0];
    hs_s         = valid_q & out_ready;
  end

  // Next-state and next-output logic of the enumerator.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    kq_d    = kq_q;
    count_d = count_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (k > 6'd32)) begin
          err_d = 1'b1;
        end else if (start) begin
          state_d = S_EMIT;
          word_d  = first_word_s;
          kq_d    = k;
          count_d = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          last_d  = (first_word_s == first_top_s);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EMIT: begin
        if (hs_s && last_q) begin
          count_d = count_q + CNT_W'(1);
          state_d = S_DONE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (hs_s) begin
          count_d = count_q + CNT_W'(1);
          word_d  = next_word_s;
          last_d  = (next_word_s == top_q_s);
        end else begin
          state_d = S_EMIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      kq_q    <= 6'd0;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      kq_q    <= kq_d;
      count_q <= count_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef HAMM_ENUM_CHECK_EN
  logic chk_err_q, chk_err_d;

  // Sticky flag: an accepted word whose weight differs from the requested one.
  always_comb begin
    chk_err_d = chk_err_q;
    if (hs_s && (state_q == S_EMIT) && ($countones(word_q) != 32'(kq_q))) begin
      chk_err_d = 1'b1;
    end else begin
      chk_err_d = chk_err_q;
    end
  end

  // Self-check flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  assign out_word  = word_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_hamm_weight_enum.sv
// Directed bench for hamm_weight_enum: checks word sequences, last/done timing, stalls, errors and reset.
module tb_hamm_weight_enum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  k;
  logic [31:0] out_word;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] count;
  logic        chk_err;

  int n_checks = 0;
  int n_err    = 0;
  int n_hs;

  hamm_weight_enum #(.WIDTH(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .k(k),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done), .err(err),
    .count(count), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference sequences built from combinatorial ordering, not from Gosper's step.
  function automatic logic [31:0] ref_word(input int kk, input int idx);
    logic [31:0] w;
    int n;
    w = 32'h0;
    n = 0;
    case (kk)
      0:  w = 32'h0000_0000;
      32: w = 32'hFFFF_FFFF;
      1:  w = 32'h1 << idx;
      31: w = ~(32'h1 << (31 - idx));
      2: begin
        for (int j = 1; j < 32; j++) begin
          for (int i = 0; i < j; i++) begin
            if (n == idx) w = (32'h1 << j) | (32'h1 << i);
            n++;
          end
        end
      end
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  task automatic do_start(input int kk);
    start = 1'b1;
    k     = 6'(kk);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_stream(input int kk, input int total, input bit rnd, input int max_hs,
                            output int hs);
    int          cyc;
    bit          fin, stalled, rdy, known;
    logic [31:0] prev, held;
    hs = 0; cyc = 0; fin = 1'b0; stalled = 1'b0; prev = 32'h0; held = 32'h0;
    known = (kk == 0) || (kk == 1) || (kk == 2) || (kk == 31) || (kk == 32);
    while (!fin && (hs < max_hs) && (cyc < 60000)) begin
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      chk("valid_in_emit", 32'(out_valid), 32'h1);
      if (stalled) chk("stall_hold", out_word, held);
      if (rdy) begin
        if (known) begin
          chk("word", out_word, ref_word(kk, hs));
        end else begin
          chk("weight", 32'($countones(out_word)), 32'(kk));
          if (hs > 0) chk("ascending", 32'(out_word > prev), 32'h1);
        end
        chk("last_flag", 32'(out_last), 32'(hs == total - 1));
        prev    = out_word;
        stalled = 1'b0;
        fin     = (hs == total - 1);
        hs++;
      end else begin
        stalled = 1'b1;
        held    = out_word;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 60000) chk("timeout", 32'h1, 32'h0);
  endtask

  task automatic finish_checks(input int total);
    chk("done_pulse", 32'(done), 32'h1);
    chk("valid_after_last", 32'(out_valid), 32'h0);
    chk("busy_after_last", 32'(busy), 32'h0);
    chk("count_total", count, 32'(total));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k = 6'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word", out_word, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", count, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // k = 2, ready always high
    do_start(2);
    chk("k2_first", out_word, 32'h3);
    chk("k2_busy", 32'(busy), 32'h1);
    run_stream(2, 496, 1'b0, 100000, n_hs);
    chk("k2_hs", 32'(n_hs), 32'd496);
    chk("k2_chk_err", 32'(chk_err), 32'h0);
    finish_checks(496);

    // k = 0 and k = 32: single word each
    do_start(0);
    chk("k0_last", 32'(out_last), 32'h1);
    run_stream(0, 1, 1'b0, 100000, n_hs);
    finish_checks(1);
    do_start(32);
    chk("k32_word", out_word, 32'hFFFF_FFFF);
    run_stream(32, 1, 1'b0, 100000, n_hs);
    finish_checks(1);

    // k = 1 with random stalls
    do_start(1);
    run_stream(1, 32, 1'b1, 100000, n_hs);
    chk("k1_hs", 32'(n_hs), 32'd32);
    finish_checks(32);

    // k = 3 interrupted by reset after 10 handshakes
    do_start(3);
    run_stream(3, 4960, 1'b0, 10, n_hs);
    chk("k3_count10", count, 32'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_word", out_word, 32'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_last", 32'(out_last), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_count", count, 32'h0);

    // k = 31 after reset
    do_start(31);
    chk("k31_first", out_word, 32'h7FFF_FFFF);
    run_stream(31, 32, 1'b0, 100000, n_hs);
    finish_checks(32);

    // k = 33 is illegal
    do_start(33);
    chk("k33_err", 32'(err), 32'h1);
    chk("k33_valid", 32'(out_valid), 32'h0);
    chk("k33_busy", 32'(busy), 32'h0);
    chk("k33_count", count, 32'd32);
    @(posedge clk); #1;
    chk("k33_err_pulse", 32'(err), 32'h0);
    chk("k33_valid_later", 32'(out_valid), 32'h0);

    // k = 4 with a second start ignored while busy
    do_start(4);
    chk("k4_first", out_word, 32'hF);
    start = 1'b1; k = 6'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("k4_restart_busy", 32'(busy), 32'h1);
    chk("k4_restart_word", out_word, 32'hF);
    run_stream(4, 35960, 1'b0, 100000, n_hs);
    chk("k4_hs", 32'(n_hs), 32'd35960);
    finish_checks(35960);
    chk("final_chk_err", 32'(chk_err), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
